core_mem_port: RTL and testbench

- Per-core initiator for the shared-memory port; one instance per core.
- Sits between a core's load/store stage and that core's slice of the shared-memory request bus (2-bit enable, address, write data, read data, ready).
- Buffers up to two core requests and drives one memory request at a time, holding it until the arbiter grants it.
- Returns read data or a write acknowledge to the core, and tolerates the memory's one-cycle read-ready latency.

---
 rtl/core_mem_port_pkg.sv | 28 ++
 rtl/core_mem_port_mem_req_fifo.sv | 67 ++++++
 rtl/core_mem_port.sv | 186 ++++++++++++++++++
 tb/tb_core_mem_port.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_port_pkg
//  Description : Shared sizes, memory-bus enable encodings and port FSM
//                state encodings for the per-core shared-memory initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_mem_port_pkg;

  // Shared register / shared address sizes
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  // Memory request enable encodings, {wr, rd}
  localparam logic [1:0] MEM_EN_IDLE = 2'b00;
  localparam logic [1:0] MEM_EN_RD   = 2'b01;
  localparam logic [1:0] MEM_EN_WR   = 2'b10;

  // Port FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR       = 2'd1,
    ST_RD       = 2'd2,
    ST_RD_DRAIN = 2'd3
  } port_state_e;

endpackage
`default_nettype wire

// File: rtl/core_mem_port_mem_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_fifo
//  Description : Two-entry synchronous request FIFO with full/empty flags.
//                Head entry is presented combinationally on o_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_fifo
  import core_mem_port_pkg::*;
#(
  parameter int WIDTH = 1 + ADDR_W + DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_entry0;
  logic [WIDTH-1:0] r_entry1;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // Refused pushes (full) and pops (empty) leave the FIFO untouched
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_data  = r_rd_ptr ? r_entry1 : r_entry0;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage written at the write pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else if (w_push) begin
      if (r_wr_ptr) r_entry1 <= i_data;
      else          r_entry0 <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_port
//  Description : Per-core shared-memory initiator. Buffers up to two core
//                requests, issues one memory request at a time and holds it
//                until the arbiter answers, then returns a registered
//                response. Optional stall timer: MEM_PORT_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_port
  import core_mem_port_pkg::*;
#(
  parameter int DATA_W         = core_mem_port_pkg::DATA_W,
  parameter int ADDR_W         = core_mem_port_pkg::ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [1:0]        mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_ready
);

  localparam int REQ_W = 1 + ADDR_W + DATA_W;

  port_state_e       r_state;
  port_state_e       w_next_state;
  logic [REQ_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_done_wr;
  logic              w_done_rd;
  logic              w_abort;
  logic              w_timeout;
  logic [1:0]        w_enable;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [DATA_W-1:0] r_cur_wdata;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;

  mem_req_fifo #(
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (req_valid),
    .i_data  ({req_we, req_addr, req_wdata}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_ready   = !w_full;
  assign mem_enable  = w_enable;
  assign mem_addr    = r_cur_addr;
  assign mem_wr_data = r_cur_wdata;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_resp_err;

  // This cycle is the last allowed stall cycle when mem_ready is still low
  assign w_timeout = (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));
  assign resp_err  = r_resp_err;

  // Count issued cycles without mem_ready; restart on each new issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (w_pop) begin
      r_stall <= '0;
    end else if ((r_state == ST_WR || r_state == ST_RD) && !mem_ready) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  // Error flag travels with its response and holds until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_err <= 1'b0;
    end else if (w_done_wr || w_done_rd || w_abort) begin
      r_resp_err <= w_abort;
    end
  end
`else
  // Without the stall timer the port waits forever and never aborts;
  // TIMEOUT_CYCLES has no influence in this build.
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and memory-bus controls; mem_ready only counts in WR/RD
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_enable     = MEM_EN_IDLE;
    w_done_wr    = 1'b0;
    w_done_rd    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = w_head[REQ_W-1] ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        w_enable = MEM_EN_WR;
        if (mem_ready) begin
          w_done_wr    = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_next_state = ST_RD_DRAIN;
        end
      end
      ST_RD: begin
        w_enable = MEM_EN_RD;
        if (mem_ready) begin
          w_done_rd    = 1'b1;
          w_next_state = ST_RD_DRAIN;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_next_state = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        // A stale ready from a re-grant may show up here and is dropped
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Current request register, held stable from issue to completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_addr  <= '0;
      r_cur_wdata <= '0;
    end else if (w_pop) begin
      r_cur_addr  <= w_head[DATA_W +: ADDR_W];
      r_cur_wdata <= w_head[DATA_W-1:0];
    end
  end

  // Registered response: pulse valid, keep data until the next response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_done_wr || w_done_rd || w_abort;
      if (w_done_rd) begin
        r_resp_rdata <= mem_rd_data;
      end else if (w_done_wr || w_abort) begin
        r_resp_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_mem_port
//  Description : Self-checking bench for core_mem_port: directed timing
//                scenarios plus a randomized traffic phase against a memory
//                model and an in-order expected-response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_port;
  import core_mem_port_pkg::*;

  localparam int DW = 8;
  localparam int AW = 10;
`ifdef MEM_PORT_TIMEOUT_EN
  localparam int TO      = 4;
  localparam int STALL_N = 2;
`else
  localparam int TO      = 255;
  localparam int STALL_N = 5;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [1:0]    mem_enable;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          mem_ready;

  always #5 clk = ~clk;

  core_mem_port #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_enable  (mem_enable),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_ready   (mem_ready)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];  // memory behind the arbiter
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];  // reference: program-order memory view
  req_t          req_q[$];
  logic [DW-1:0] exp_q[$];
  bit            auto_mem;
  bit            mon_en;
  bit            gaps;
  int            grant_pct;
  bit            rd_pend;
  logic [AW-1:0] rd_addr;
  int            stall_run;
  logic [1:0]    prev_en;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wd;
  logic          prev_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of automatic traffic: check response, model memory, drive core
  task automatic step();
    bit   grant;
    req_t r;
    if (mon_en && resp_valid) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
      else begin
        chk("resp_rdata", resp_rdata, exp_q.pop_front());
        chk("resp_err", resp_err, 0);
      end
    end
    if (auto_mem && prev_en != MEM_EN_IDLE && !prev_rdy) begin
      chk("hold_enable", mem_enable, prev_en);
      chk("hold_addr", mem_addr, prev_addr);
      if (prev_en == MEM_EN_WR) chk("hold_wdata", mem_wr_data, prev_wd);
    end
    if (auto_mem) begin
      mem_ready   = 1'b0;
      mem_rd_data = DW'($urandom);
      if (rd_pend) begin
        mem_ready   = 1'b1;
        mem_rd_data = mem_arr[rd_addr];
        rd_pend     = 1'b0;
      end
      if (mem_enable != MEM_EN_IDLE) begin
        grant     = ($urandom_range(99) < grant_pct) || (stall_run >= 2);
        stall_run = grant ? 0 : stall_run + 1;
        if (grant && mem_enable == MEM_EN_WR) begin
          mem_ready         = 1'b1;
          mem_arr[mem_addr] = mem_wr_data;
        end
        if (grant && mem_enable == MEM_EN_RD) begin
          rd_pend = 1'b1;
          rd_addr = mem_addr;
        end
      end else begin
        stall_run = 0;
      end
    end
    if (req_q.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
      req_valid = 1'b1;
      {req_we, req_addr, req_wdata} = req_q[0];
      if (req_ready) begin
        r = req_q.pop_front();
        if (r.we) begin
          ref_mem[r.addr] = r.wdata;
          exp_q.push_back('0);
        end else begin
          exp_q.push_back(ref_mem[r.addr]);
        end
      end
    end else begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
    end
    prev_en   = mem_enable;
    prev_addr = mem_addr;
    prev_wd   = mem_wr_data;
    prev_rdy  = mem_ready;
    tick();
  endtask

  task automatic start_auto(input int pct);
    auto_mem  = 1'b1;
    mon_en    = 1'b1;
    grant_pct = pct;
    rd_pend   = 1'b0;
    stall_run = 0;
    prev_en   = MEM_EN_IDLE;
    prev_rdy  = 1'b0;
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    for (int c = 0; c < budget && !(req_q.size() == 0 && exp_q.size() == 0); c++) step();
    chk(tag, (req_q.size() == 0 && exp_q.size() == 0), 1);
    for (int c = 0; c < 4; c++) step();
  endtask

  initial begin
    int nresp;
    int quiet;
    for (int i = 0; i < (1 << AW); i++) begin
      mem_arr[i] = DW'(i * 37 + 11);
      ref_mem[i] = DW'(i * 37 + 11);
    end
    auto_mem = 1'b0; mon_en = 1'b0; gaps = 1'b0; grant_pct = 0;
    rd_pend = 1'b0; stall_run = 0; prev_en = '0; prev_rdy = 1'b0;
    prev_addr = '0; prev_wd = '0; rd_addr = '0;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rd_data = '0;

    // Reset state
    tick();
    chk("rst_enable", mem_enable, 2'b00);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wr_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_req_ready", req_ready, 1);

    // Write 0x105/0xA5 with mem_ready already high
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h105; req_wdata = 8'hA5; mem_ready = 1'b1;
    chk("wr_req_ready", req_ready, 1);
    tick();                                           // T+1
    req_valid = 1'b0;
    chk("wr_t1_enable", mem_enable, 2'b00);
    tick();                                           // T+2
    chk("wr_t2_enable", mem_enable, 2'b10);
    chk("wr_t2_addr", mem_addr, 10'h105);
    chk("wr_t2_wdata", mem_wr_data, 8'hA5);
    chk("wr_t2_resp_valid", resp_valid, 0);
    tick();                                           // T+3
    chk("wr_t3_resp_valid", resp_valid, 1);
    chk("wr_t3_resp_rdata", resp_rdata, 0);
    chk("wr_t3_resp_err", resp_err, 0);
    chk("wr_t3_enable", mem_enable, 2'b00);
    mem_ready = 1'b0;
    tick();
    chk("wr_t4_resp_valid", resp_valid, 0);

    // Read 0x105, ready one cycle after grant, then a stale ready in drain
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h105; req_wdata = 8'h3C;
    tick();                                           // T+1
    req_valid = 1'b0;
    tick();                                           // T+2
    chk("rd_t2_enable", mem_enable, 2'b01);
    chk("rd_t2_addr", mem_addr, 10'h105);
    tick();                                           // T+3
    chk("rd_t3_enable", mem_enable, 2'b01);
    chk("rd_t3_resp_valid", resp_valid, 0);
    mem_ready = 1'b1; mem_rd_data = 8'hA5;
    tick();                                           // T+4
    chk("rd_t4_resp_valid", resp_valid, 1);
    chk("rd_t4_resp_rdata", resp_rdata, 8'hA5);
    chk("rd_t4_enable", mem_enable, 2'b00);
    mem_ready = 1'b1; mem_rd_data = 8'h77;
    tick();                                           // T+5
    chk("rd_t5_no_second_resp", resp_valid, 0);
    mem_ready = 1'b0;
    tick();
    chk("rd_t6_no_second_resp", resp_valid, 0);
    chk("rd_t6_rdata_held", resp_rdata, 8'hA5);
    chk("rd_t6_enable", mem_enable, 2'b00);

    // Stalled write: request held stable, exactly one response
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h2C3; req_wdata = 8'h5A;
    tick();
    req_valid = 1'b0;
    tick();
    nresp = 0;
    for (int i = 0; i < STALL_N; i++) begin
      chk("stall_enable", mem_enable, 2'b10);
      chk("stall_addr", mem_addr, 10'h2C3);
      chk("stall_wdata", mem_wr_data, 8'h5A);
      nresp += int'(resp_valid);
      tick();
    end
    mem_ready = 1'b1;
    chk("stall_enable_last", mem_enable, 2'b10);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nresp += int'(resp_valid);
      tick();
    end
    chk("stall_resp_count", nresp, 1);

    // Three back-to-back requests behind a stalled write
    start_auto(0);
    req_q.push_back({1'b1, 10'h010, 8'h11});
    req_q.push_back({1'b0, 10'h010, 8'h00});
    req_q.push_back({1'b1, 10'h011, 8'h22});
    req_q.push_back({1'b0, 10'h011, 8'h00});
    step(); step(); step();
    chk("b2b_req_ready_low", req_ready, 0);
    chk("b2b_enable_wr", mem_enable, 2'b10);
    chk("b2b_third_waiting", req_q.size(), 1);
    grant_pct = 100;
    run_until_drained("b2b_drained", 60);
    auto_mem = 1'b0; mon_en = 1'b0;
    req_valid = 1'b0; mem_ready = 1'b0;

    // Reset in the middle of a read with another read queued
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h105; req_wdata = 8'hC3;
    tick();
    req_addr = 10'h106;
    tick();
    req_valid = 1'b0;
    chk("mid_rst_pre_enable", mem_enable, 2'b01);
    reset = 1'b0;
    #1;
    chk("mid_rst_enable", mem_enable, 2'b00);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wr_data, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_req_ready", req_ready, 1);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      quiet += int'(resp_valid || mem_enable != 2'b00);
      tick();
    end
    chk("mid_rst_quiet", quiet, 0);
    start_auto(100);
    req_q.push_back({1'b0, 10'h105, 8'h00});
    run_until_drained("post_rst_read", 40);
    auto_mem = 1'b0; mon_en = 1'b0;
    req_valid = 1'b0; mem_ready = 1'b0;

`ifdef MEM_PORT_TIMEOUT_EN
    // Memory never answers: abort after TO stall cycles with an error
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h105; req_wdata = 8'h00;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < TO; i++) begin
      chk("to_enable_held", mem_enable, 2'b01);
      tick();
    end
    chk("to_enable_dropped", mem_enable, 2'b00);
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_rdata", resp_rdata, 0);
    tick();
    chk("to_resp_pulse", resp_valid, 0);
    tick();
`endif

    // Randomized traffic over a small address window with contention
    start_auto(60);
    gaps = 1'b1;
    for (int i = 0; i < 80; i++) begin
      req_q.push_back({1'($urandom), AW'(10'h300 + $urandom_range(7)), DW'($urandom)});
    end
    run_until_drained("rand_drained", 3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
